// File: rtl/fifo_rd_stream_adapter.sv
// Drain stage for the sync FIFO: credit-based reads, skid buffer for the 1-cycle read
// latency, valid/ready stream output, delivered-word counter and sticky underflow flag.

module fifo_rd_stream_adapter_chk #(
  parameter int DATA_WIDTH = 16,
  parameter int BUF_DEPTH  = 4,
  parameter int OCC_W      = 3
) (
  input logic                  clk,
  input logic                  rst_n,
  input logic [OCC_W-1:0]      count,
  input logic                  fifo_rd_en,
  input logic                  fifo_empty,
  input logic                  m_valid,
  input logic                  m_ready,
  input logic [DATA_WIDTH-1:0] m_data
);
  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(BUF_DEPTH);

  count_bound: assert property (@(posedge clk) disable iff (!rst_n) count <= DEPTH_C);
  no_empty_read: assert property (@(posedge clk) disable iff (!rst_n) !(fifo_rd_en && fifo_empty));
  stream_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (m_valid && !m_ready) |=> (m_valid && $stable(m_data)));
endmodule

module fifo_rd_stream_adapter #(
  parameter int DATA_WIDTH = 16,
  parameter int BUF_DEPTH  = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  underflow_err,
  input  logic                  clear_err
);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int SUM_W = OCC_W + 1;
  localparam logic [SUM_W-1:0] DEPTH_C = SUM_W'(BUF_DEPTH);

  logic [DATA_WIDTH-1:0] buf_r [BUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [OCC_W-1:0]      count_r;
  logic [OCC_W-1:0]      count_nxt_s;
  logic [SUM_W-1:0]      occ_s;
  logic                  inflight_r;
  logic                  started_r;
  logic                  rd_en_s;
  logic                  xfer_s;
  logic [CNT_WIDTH-1:0]  rd_count_r;
  logic                  underflow_err_r;

  // Read credit: buffered words plus the one possibly in flight must leave room.
  always_comb begin
    occ_s   = {1'b0, count_r} + {{OCC_W{1'b0}}, inflight_r};
    rd_en_s = 1'b0;
    if (started_r && !fifo_empty && (occ_s < DEPTH_C)) begin
      rd_en_s = 1'b1;
    end else begin
      rd_en_s = 1'b0;
    end
  end

  assign fifo_rd_en    = rd_en_s;
  assign m_valid       = (count_r != OCC_W'(0));
  assign m_data        = buf_r[rd_ptr_r];
  assign xfer_s        = m_valid & m_ready;
  assign rd_count      = rd_count_r;
  assign underflow_err = underflow_err_r;

  // Occupancy follows capture (+1) and transfer (-1); both together cancel.
  always_comb begin
    count_nxt_s = count_r;
    case ({inflight_r, xfer_s})
      2'b10:   count_nxt_s = count_r + OCC_W'(1);
      2'b01:   count_nxt_s = count_r - OCC_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Control state: read pipeline, pointers, occupancy, counter and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started_r       <= 1'b0;
      inflight_r      <= 1'b0;
      wr_ptr_r        <= PTR_W'(0);
      rd_ptr_r        <= PTR_W'(0);
      count_r         <= OCC_W'(0);
      rd_count_r      <= CNT_WIDTH'(0);
      underflow_err_r <= 1'b0;
    end else begin
      started_r  <= 1'b1;
      inflight_r <= rd_en_s;
      count_r    <= count_nxt_s;
      if (inflight_r) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (xfer_s) begin
        rd_ptr_r   <= rd_ptr_r + PTR_W'(1);
        rd_count_r <= rd_count_r + CNT_WIDTH'(1);
      end
      // Set has priority over clear so an underflow is never lost.
      if (fifo_underflow)  underflow_err_r <= 1'b1;
      else if (clear_err)  underflow_err_r <= 1'b0;
      else                 underflow_err_r <= underflow_err_r;
    end
  end

  // Skid buffer storage; cleared on reset so m_data reads zero while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) buf_r[i] <= DATA_WIDTH'(0);
    end else if (inflight_r) begin
      buf_r[wr_ptr_r] <= fifo_data_out;
    end
  end

  fifo_rd_stream_adapter_chk #(
    .DATA_WIDTH(DATA_WIDTH),
    .BUF_DEPTH (BUF_DEPTH),
    .OCC_W     (OCC_W)
  ) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .count     (count_r),
    .fifo_rd_en(rd_en_s),
    .fifo_empty(fifo_empty),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data)
  );
endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench for fifo_rd_stream_adapter: queue-based FIFO model plus an occupancy/scoreboard
// reference (reads issued, words arrived, words delivered) checked every cycle.

module tb_fifo_rd_stream_adapter;
  logic        clk;
  logic        rst_n;
  logic        fifo_rd_en;
  logic [15:0] fifo_data_out;
  logic        fifo_empty;
  logic        fifo_underflow;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] rd_count;
  logic        underflow_err;
  logic        clear_err;

  int checks = 0;
  int errors = 0;

  logic [15:0] fq[$];
  logic [15:0] sb[$];
  int popped, arrived, delivered, since_rst, rd_pulses;
  bit exp_err;

  fifo_rd_stream_adapter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_data_out (fifo_data_out),
    .fifo_empty    (fifo_empty),
    .fifo_underflow(fifo_underflow),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .rd_count      (rd_count),
    .underflow_err (underflow_err),
    .clear_err     (clear_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    popped = 0; arrived = 0; delivered = 0; since_rst = 0; exp_err = 1'b0;
    sb.delete();
  endtask

  task automatic push(input logic [15:0] w);
    fq.push_back(w);
  endtask

  // One clock: drive at negedge, check settled outputs, advance model after posedge.
  task automatic tick(input bit rdy, input bit uf = 1'b0, input bit clr = 1'b0);
    bit rd_act, exp_rd, exp_v;
    logic [15:0] w;
    @(negedge clk);
    m_ready = rdy; fifo_underflow = uf; clear_err = clr;
    fifo_empty = (fq.size() == 0);
    #1;
    exp_rd = (since_rst >= 1) && (fq.size() != 0) && ((popped - delivered) < 4);
    exp_v  = (arrived > delivered);
    chk("rd_en", 32'(fifo_rd_en), 32'(exp_rd));
    chk("m_valid", 32'(m_valid), 32'(exp_v));
    if (exp_v) chk("m_data", 32'(m_data), 32'(sb[delivered]));
    chk("rd_count", rd_count, 32'(delivered));
    chk("underflow_err", 32'(underflow_err), 32'(exp_err));
    rd_act = fifo_rd_en;
    @(posedge clk);
    #1;
    if (exp_v && rdy) delivered++;
    arrived = popped;
    if (rd_act) begin
      rd_pulses++;
      chk("read_nonempty", 32'(fq.size() != 0), 32'd1);
      if (fq.size() != 0) begin
        w = fq.pop_front();
        fifo_data_out = w;
        sb.push_back(w);
        popped++;
      end
    end
    if (uf) exp_err = 1'b1;
    else if (clr) exp_err = 1'b0;
    since_rst++;
    fifo_empty = (fq.size() == 0);
  endtask

  initial begin
    rst_n = 1'b0; m_ready = 1'b0; fifo_empty = 1'b1; fifo_underflow = 1'b0;
    clear_err = 1'b0; fifo_data_out = 16'h0000; rd_pulses = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_rd_count", rd_count, 32'd0);
    chk("rst_err", 32'(underflow_err), 32'd0);
    rst_n = 1'b1;

    // 1: three words with m_ready=1; also first cycle after reset must not read
    push(16'h00A1); push(16'h00A2); push(16'h00A3);
    repeat (7) tick(1'b1);
    chk("t1_count", rd_count, 32'd3);

    // 2: eight words, 10 stalled cycles, then drain
    for (int i = 0; i < 8; i++) push(16'h0B00 + 16'(i));
    rd_pulses = 0;
    repeat (10) tick(1'b0);
    chk("t2_stall_reads", 32'(rd_pulses), 32'd4);
    chk("t2_head", 32'(m_data), 32'h0B00);
    repeat (10) tick(1'b1);
    chk("t2_count", rd_count, 32'd11);

    // 3: ready toggling with the FIFO kept non-empty
    for (int i = 0; i < 24; i++) begin
      if (fq.size() < 3) push(16'h0C00 + 16'(i));
      tick(i[0] == 1'b0);
    end
    repeat (8) tick(1'b1);

    // 4: FIFO empty throughout
    rd_pulses = 0;
    repeat (6) tick(1'b1);
    chk("t4_no_reads", 32'(rd_pulses), 32'd0);

    // 5: sticky underflow, set beats clear, clear alone clears
    tick(1'b1, 1'b1, 1'b0);
    repeat (2) tick(1'b1);
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b1);
    chk("t5_cleared", 32'(underflow_err), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) != 0 && fq.size() < 12) push(16'($urandom));
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 9) == 0));
    end
    repeat (20) tick(1'b1);

    // 6: async reset with 3 buffered and 1 in flight; no stale word afterwards
    for (int i = 0; i < 8; i++) push(16'h0D00 + 16'(i));
    repeat (4) tick(1'b0);
    chk("t6_pre_valid", 32'(m_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 32'(m_valid), 32'd0);
    chk("t6_async_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("t6_async_count", rd_count, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) tick(1'b1);
    chk("t6_count", rd_count, 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
